// File: rtl/qformat_pkg.sv
// Shared (N,Q) sign-magnitude fixed-point constants and the divider FSM state type.
package qformat_pkg;

  localparam int unsigned QF_N = 32;
  localparam int unsigned QF_Q = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } qdiv_state_e;

endpackage

// File: rtl/qdiv_step.sv
// One restoring-division step: shift in the next dividend bit, trial subtract,
// emit one quotient bit into the low end of the shift register.
module qdiv_step
  import qformat_pkg::*;
#(
  parameter int unsigned Q = QF_Q,
  parameter int unsigned N = QF_N
) (
  input  logic [N-1:0]   i_rem,
  input  logic [N+Q-2:0] i_dq,
  input  logic [N-2:0]   i_div,
  output logic [N-1:0]   o_rem_c,
  output logic [N+Q-2:0] o_dq_c
);

  localparam int unsigned SW = N - 1 + Q;

  logic [N:0] shifted;
  logic [N:0] div_ext;
  logic [N:0] trial;
  logic       q_bit;

  always_comb begin
    shifted = {i_rem, i_dq[SW-1]};
    div_ext = {2'b00, i_div};
    trial   = shifted - div_ext;
    q_bit   = (shifted >= div_ext);
    o_rem_c = q_bit ? N'(trial) : N'(shifted);
    o_dq_c  = {i_dq[SW-2:0], q_bit};
  end

endmodule

// File: rtl/qdiv.sv
// Sequential sign-magnitude (N,Q) fixed-point divider, one quotient bit per cycle,
// with overflow and divide-by-zero flagging.
module qdiv
  import qformat_pkg::*;
#(
  parameter int unsigned Q = QF_Q,
  parameter int unsigned N = QF_N
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [N-1:0] i_dividend,
  input  logic [N-1:0] i_divisor,
  output logic [N-1:0] o_quotient,
  output logic         o_complete,
  output logic         o_busy,
  output logic         o_ovr
);

  localparam int unsigned MW = N - 1;
  localparam int unsigned SW = N - 1 + Q;
  localparam int unsigned CW = $clog2(N + Q);

  qdiv_state_e    state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   rem_q, rem_d;
  logic [SW-1:0]  dq_q, dq_d;
  logic [MW-1:0]  div_q, div_d;
  logic           sign_q, sign_d;
  logic [N-1:0]   quo_q, quo_d;
  logic           ovr_q, ovr_d;
  logic           busy_q, busy_d;
  logic           cmp_q, cmp_d;

  logic [N-1:0]   step_rem_c;
  logic [SW-1:0]  step_dq_c;

  qdiv_step #(.Q(Q), .N(N)) u_step (
    .i_rem   (rem_q),
    .i_dq    (dq_q),
    .i_div   (div_q),
    .o_rem_c (step_rem_c),
    .o_dq_c  (step_dq_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    div_d   = div_q;
    sign_d  = sign_q;
    quo_d   = quo_q;
    ovr_d   = ovr_q;
    busy_d  = busy_q;
    cmp_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          rem_d  = '0;
          dq_d   = {i_dividend[N-2:0], {Q{1'b0}}};
          div_d  = i_divisor[N-2:0];
          sign_d = i_dividend[N-1] ^ i_divisor[N-1];
          ovr_d  = 1'b0;
          busy_d = 1'b1;
          // A zero divisor skips RUN but keeps a fixed two-cycle turnaround.
          if (i_divisor[N-2:0] == '0) begin
            state_d = ST_DONE;
            cnt_d   = CW'(1);
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end
        end
      end

      ST_RUN: begin
        rem_d = step_rem_c;
        dq_d  = step_dq_c;
        if (cnt_q == CW'(SW - 1)) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_DONE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          cmp_d   = 1'b1;
          if (div_q == '0) begin
            quo_d = {sign_q, {MW{1'b1}}};
            ovr_d = 1'b1;
          end else begin
            // Upper Q quotient bits nonzero means the magnitude does not fit; truncate.
            quo_d = {sign_q, dq_q[MW-1:0]};
            ovr_d = |dq_q[SW-1:MW];
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      div_q   <= '0;
      sign_q  <= 1'b0;
      quo_q   <= '0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
      cmp_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      div_q   <= div_d;
      sign_q  <= sign_d;
      quo_q   <= quo_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
      cmp_q   <= cmp_d;
    end
  end

  assign o_quotient = quo_q;
  assign o_ovr      = ovr_q;
  assign o_busy     = busy_q;
  assign o_complete = cmp_q;

endmodule

// File: tb/tb_qdiv.sv
// Scoreboard bench for qdiv: stimulus pushes expected results, a negedge monitor
// pops and compares on every o_complete pulse.
module tb_qdiv;
  import qformat_pkg::*;

  localparam int unsigned N = QF_N;
  localparam int unsigned Q = QF_Q;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b1;
  logic         i_start = 1'b0;
  logic [N-1:0] i_dividend = '0;
  logic [N-1:0] i_divisor = '0;
  logic [N-1:0] o_quotient;
  logic         o_complete;
  logic         o_busy;
  logic         o_ovr;

  qdiv #(.Q(Q), .N(N)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_dividend (i_dividend),
    .i_divisor  (i_divisor),
    .o_quotient (o_quotient),
    .o_complete (o_complete),
    .o_busy     (o_busy),
    .o_ovr      (o_ovr)
  );

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] quo;
    logic         ovr;
    int           lat;
    int           t0;   // cycle of the accepting edge; -1 = edge right after previous complete
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   last_cmp = -100;
  int   mon_t0;
  logic prev_cmp = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division of the magnitudes scaled by 2^Q.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int t0);
    exp_t            e;
    longint unsigned ma, mb, qv;
    logic            s;
    s    = a[N-1] ^ b[N-1];
    ma   = 64'(a[N-2:0]);
    mb   = 64'(b[N-2:0]);
    e.t0 = t0;
    if (mb == 0) begin
      e.quo = {s, {(N-1){1'b1}}};
      e.ovr = 1'b1;
      e.lat = 2;
    end else begin
      qv    = (ma << Q) / mb;
      e.ovr = ((qv >> (N - 1)) != 0);
      e.quo = {s, qv[N-2:0]};
      e.lat = int'(N + Q);
    end
    return e;
  endfunction

  function automatic logic [N-1:0] rnd_val(input bit allow_zero);
    logic [N-1:0] v;
    int           sh;
    sh = int'($urandom_range(0, N - 2));
    v  = N'($urandom) >> sh;
    if (allow_zero && ($urandom_range(0, 7) == 0)) v = '0;
    v[N-1] = 1'($urandom_range(0, 1));
    return v;
  endfunction

  // Monitor: every complete pulse is matched against the oldest expectation.
  always @(negedge i_clk) begin
    if (i_rst_n && o_complete) begin
      check("complete_single_cycle", 64'(prev_cmp), 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_complete: got quotient 0x%0h want no pulse", o_quotient);
      end else begin
        mon_e  = sb.pop_front();
        mon_t0 = (mon_e.t0 < 0) ? last_cmp + 1 : mon_e.t0;
        check("quotient", 64'(o_quotient), 64'(mon_e.quo));
        check("ovr", 64'(o_ovr), 64'(mon_e.ovr));
        check("latency", 64'(cyc - mon_t0), 64'(mon_e.lat));
        check("busy_low_at_complete", 64'(o_busy), 64'd0);
      end
      last_cmp = cyc;
    end
    prev_cmp = o_complete;
  end

  task automatic wait_cmp(input int budget);
    int k;
    k = 0;
    do begin
      @(negedge i_clk);
      k++;
    end while (!o_complete && k < budget);
    if (!o_complete) begin
      total++;
      bad++;
      $display("FAIL timeout: no o_complete within %0d cycles, want one", budget);
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input exp_t e);
    @(negedge i_clk);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    e.t0       = cyc + 1;
    sb.push_back(e);
    @(negedge i_clk);
    i_start    = 1'b0;
    i_dividend = N'($urandom);
    i_divisor  = N'($urandom);
  endtask

  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        input logic [N-1:0] quo, input logic ovr, input int lat);
    exp_t e;
    e.quo = quo;
    e.ovr = ovr;
    e.lat = lat;
    e.t0  = 0;
    issue(a, b, e);
    wait_cmp(100);
  endtask

  initial begin
    exp_t         e;
    logic [N-1:0] a, b;

    #2 i_rst_n = 1'b0;
    repeat (3) @(negedge i_clk);
    check("reset_quotient", 64'(o_quotient), 64'd0);
    check("reset_complete", 64'(o_complete), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_ovr", 64'(o_ovr), 64'd0);
    i_rst_n = 1'b1;

    run_op(32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 47);
    run_op(32'h8001_8000, 32'h0001_0000, 32'h8000_C000, 1'b0, 47);
    run_op(32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 47);
    run_op(32'h4E20_0000, 32'h0000_4000, 32'h1C40_0000, 1'b1, 47);
    run_op(32'h0000_8000, 32'h0000_0000, 32'h7FFF_FFFF, 1'b1, 2);
    run_op(32'h0000_8000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
    run_op(32'h8000_0000, 32'h0001_0000, 32'h8000_0000, 1'b0, 47);

    // Start pulse with new operands mid-RUN must be ignored.
    e.quo = 32'h0000_C000; e.ovr = 1'b0; e.lat = 47; e.t0 = 0;
    issue(32'h0001_8000, 32'h0001_0000, e);
    repeat (10) @(negedge i_clk);
    check("busy_mid_run", 64'(o_busy), 64'd1);
    i_start    = 1'b1;
    i_dividend = 32'h0005_0000;
    i_divisor  = 32'h0000_8000;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cmp(100);

    // Reset during RUN cycle 20 clears everything at once.
    run_op(32'h0004_0000, 32'h0000_4000, 32'h0008_0000, 1'b0, 47);
    e.quo = 32'h0000_C000; e.ovr = 1'b0; e.lat = 47; e.t0 = 0;
    issue(32'h0001_8000, 32'h0001_0000, e);
    repeat (19) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check("midrun_reset_quotient", 64'(o_quotient), 64'd0);
    check("midrun_reset_complete", 64'(o_complete), 64'd0);
    check("midrun_reset_busy", 64'(o_busy), 64'd0);
    check("midrun_reset_ovr", 64'(o_ovr), 64'd0);
    sb.delete();
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    run_op(32'h0001_8000, 32'h0001_0000, 32'h0000_C000, 1'b0, 47);

    for (int i = 0; i < 40; i++) begin
      a = rnd_val(1'b0);
      b = rnd_val(1'b1);
      e = model(a, b, 0);
      issue(a, b, e);
      wait_cmp(100);
    end

    // Back-to-back with i_start held high; operands change right after each complete.
    @(negedge i_clk);
    a = rnd_val(1'b0);
    b = rnd_val(1'b0);
    i_dividend = a;
    i_divisor  = b;
    i_start    = 1'b1;
    sb.push_back(model(a, b, cyc + 1));
    for (int k = 0; k < 3; k++) begin
      wait_cmp(100);
      a = rnd_val(1'b0);
      b = (k == 1) ? 32'h8000_0000 : rnd_val(1'b0);
      i_dividend = a;
      i_divisor  = b;
      sb.push_back(model(a, b, -1));
    end
    @(negedge i_clk);
    i_start = 1'b0;
    wait_cmp(100);

    repeat (5) @(negedge i_clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
